// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N_INIT initiators share one target port.
// An owner keeps the grant for its whole cyc; an optional watchdog aborts accesses that never terminate.
module wb_rr_arbiter #(
    parameter int N_INIT    = 2,
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int TIMEOUT   = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_INIT*ADR_WIDTH-1:0]     i_adr,
    input  logic [N_INIT*DAT_WIDTH-1:0]     i_dat_w,
    output logic [DAT_WIDTH-1:0]            i_dat_r,
    input  logic [N_INIT-1:0]               i_cyc,
    input  logic [N_INIT-1:0]               i_stb,
    input  logic [N_INIT*(DAT_WIDTH/8)-1:0] i_sel,
    input  logic [N_INIT-1:0]               i_we,
    output logic [N_INIT-1:0]               i_ack,
    output logic [N_INIT-1:0]               i_err,
    output logic [ADR_WIDTH-1:0]            t_adr,
    output logic [DAT_WIDTH-1:0]            t_dat_w,
    output logic [(DAT_WIDTH/8)-1:0]        t_sel,
    output logic                            t_we,
    output logic                            t_cyc,
    output logic                            t_stb,
    input  logic [DAT_WIDTH-1:0]            t_dat_r,
    input  logic                            t_ack,
    input  logic                            t_err,
    output logic [N_INIT-1:0]               gnt,
    output logic [1:0]                      dbg_state
);

    // Handshake: a beat is offered while cyc & stb are high and completes in the
    // cycle the target raises ack (or err); stb may stay high for back-to-back beats.

    localparam int SW  = DAT_WIDTH / 8;
    localparam int PW  = (N_INIT > 1) ? $clog2(N_INIT) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Debug encoding on dbg_state: 0 = IDLE, 1 = GRANT, 2 = ABORT.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N_INIT-1:0] gnt_nxt;
    logic [PW-1:0]    owner, owner_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [WDW-1:0]   wd_cnt, wd_nxt;

    logic [N_INIT-1:0] req;
    logic              found;
    logic [PW-1:0]     pick;
    logic              owner_cyc;
    logic              stalled;

    assign req       = i_cyc & i_stb;
    assign owner_cyc = i_cyc[owner];
    assign i_dat_r   = t_dat_r;
    assign dbg_state = state;

    // Circular search starting at ptr; the first requester found wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < N_INIT; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N_INIT;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            owner  <= '0;
            ptr    <= '0;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            owner  <= owner_nxt;
            ptr    <= ptr_nxt;
            wd_cnt <= wd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        wd_nxt    = wd_cnt;
        t_adr     = '0;
        t_dat_w   = '0;
        t_sel     = '0;
        t_we      = 1'b0;
        t_cyc     = 1'b0;
        t_stb     = 1'b0;
        i_ack     = '0;
        i_err     = '0;
        stalled   = 1'b0;

        case (state)
            ST_IDLE: begin
                wd_nxt = '0;
                if (found) begin
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    owner_nxt     = pick;
                    ptr_nxt       = PW'((int'(pick) + 1) % N_INIT);
                    state_nxt     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                t_adr        = i_adr[owner*ADR_WIDTH +: ADR_WIDTH];
                t_dat_w      = i_dat_w[owner*DAT_WIDTH +: DAT_WIDTH];
                t_sel        = i_sel[owner*SW +: SW];
                t_we         = i_we[owner];
                t_cyc        = owner_cyc;
                t_stb        = owner_cyc & i_stb[owner];
                i_ack[owner] = t_ack;
                i_err[owner] = t_err;
                stalled      = t_stb & ~t_ack & ~t_err;

                if (!owner_cyc) begin
                    gnt_nxt   = '0;
                    wd_nxt    = '0;
                    state_nxt = ST_IDLE;
                end else if (TIMEOUT > 0) begin
                    // An ack arriving in the expiry cycle clears stalled, so it wins.
                    if (!stalled) begin
                        wd_nxt = '0;
                    end else if (wd_cnt >= WDW'(TIMEOUT)) begin
                        i_err[owner] = 1'b1;
                        wd_nxt       = '0;
                        state_nxt    = ST_ABORT;
                    end else begin
                        wd_nxt = wd_cnt + WDW'(1);
                    end
                end
            end

            ST_ABORT: begin
                wd_nxt = '0;
                if (!owner_cyc) begin
                    gnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with four initiators and an 8-cycle watchdog.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clock;
    logic              reset;
    logic [N*AW-1:0]   i_adr;
    logic [N*DW-1:0]   i_dat_w;
    logic [DW-1:0]     i_dat_r;
    logic [N-1:0]      i_cyc;
    logic [N-1:0]      i_stb;
    logic [N*DW/8-1:0] i_sel;
    logic [N-1:0]      i_we;
    logic [N-1:0]      i_ack;
    logic [N-1:0]      i_err;
    logic [AW-1:0]     t_adr;
    logic [DW-1:0]     t_dat_w;
    logic [DW/8-1:0]   t_sel;
    logic              t_we;
    logic              t_cyc;
    logic              t_stb;
    logic [DW-1:0]     t_dat_r;
    logic              t_ack;
    logic              t_err;
    logic [N-1:0]      gnt;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    wb_rr_arbiter #(.N_INIT(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_sel(i_sel), .i_we(i_we),
        .i_ack(i_ack), .i_err(i_err),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel), .t_we(t_we),
        .t_cyc(t_cyc), .t_stb(t_stb),
        .t_dat_r(t_dat_r), .t_ack(t_ack), .t_err(t_err),
        .gnt(gnt), .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        i_cyc[k]            = cyc;
        i_stb[k]            = stb;
        i_we[k]             = we;
        i_adr[k*AW +: AW]   = adr;
        i_dat_w[k*DW +: DW] = dat;
        i_sel[k*4 +: 4]     = 4'hF;
    endtask

    initial begin
        logic [N-1:0] exp_oh;
        int order [5] = '{0, 1, 2, 3, 0};

        reset   = 1'b1;
        i_adr   = '0;
        i_dat_w = '0;
        i_cyc   = '0;
        i_stb   = '0;
        i_sel   = '0;
        i_we    = '0;
        t_dat_r = '0;
        t_ack   = 1'b0;
        t_err   = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_gnt", gnt, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_t_cyc", t_cyc, 0);
        chk("rst_i_ack", i_ack, 0);
        reset = 1'b0;

        // 1: asynchronous reset mid-GRANT, initiator 0 first afterwards
        drive(0, 1, 1, 0, 32'h0000_0010, 32'h0);
        drive(1, 1, 1, 0, 32'h0000_0020, 32'h0);
        settle();
        chk("t1_idle_t_cyc", t_cyc, 0);
        tick();
        chk("t1_gnt0", gnt, 4'b0001);
        chk("t1_t_cyc", t_cyc, 1);
        chk("t1_t_adr", t_adr, 32'h10);
        reset = 1'b1;
        #1;
        chk("t1_async_t_cyc", t_cyc, 0);
        chk("t1_async_gnt", gnt, 0);
        chk("t1_async_state", dbg_state, 0);
        #1;
        reset = 1'b0;
        tick();
        chk("t1_regrant0", gnt, 4'b0001);
        i_cyc = '0;
        i_stb = '0;
        tick();
        chk("t1_release", gnt, 0);

        // 2: single initiator write, target acks on the fourth GRANT cycle
        drive(1, 1, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF);
        tick();
        chk("t2_gnt", gnt, 4'b0010);
        chk("t2_t_adr", t_adr, 32'h100);
        chk("t2_t_dat_w", t_dat_w, 32'hDEAD_BEEF);
        chk("t2_t_we", t_we, 1);
        chk("t2_t_sel", t_sel, 4'hF);
        chk("t2_t_stb", t_stb, 1);
        chk("t2_no_ack", i_ack, 0);
        tick();
        tick();
        tick();
        t_ack = 1'b1;
        settle();
        chk("t2_ack", i_ack, 4'b0010);
        chk("t2_no_err", i_err, 0);
        tick();
        t_ack = 1'b0;
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        settle();
        chk("t2_drop_t_cyc", t_cyc, 0);
        chk("t2_drop_gnt_held", gnt, 4'b0010);
        chk("t2_ack_once", i_ack, 0);
        tick();
        chk("t2_gnt_idle", gnt, 0);

        // 3: four-way contention with single-beat cycles
        i_cyc = '1;
        i_stb = '1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_oh = '0;
            exp_oh[order[i]] = 1'b1;
            chk($sformatf("t3_gnt_%0d", i), gnt, exp_oh);
            t_ack = 1'b1;
            settle();
            chk($sformatf("t3_ack_%0d", i), i_ack, exp_oh);
            tick();
            t_ack = 1'b0;
            i_cyc[order[i]] = 1'b0;
            i_stb[order[i]] = 1'b0;
            settle();
            chk($sformatf("t3_drop_%0d", i), t_cyc, 0);
            tick();
            chk($sformatf("t3_idle_%0d", i), gnt, 0);
            i_cyc[order[i]] = 1'b1;
            i_stb[order[i]] = 1'b1;
        end
        i_cyc = '0;
        i_stb = '0;
        tick();

        // 4: burst lock, initiator 1 waits for initiator 0 to drop cyc
        drive(0, 1, 1, 0, 32'h0000_0200, 32'h0);
        tick();
        chk("t4_gnt0", gnt, 4'b0001);
        drive(1, 1, 1, 0, 32'h0000_0300, 32'h0);
        for (int b = 0; b < 4; b++) begin
            i_adr[0 +: AW] = 32'h0000_0200 + 32'(b * 4);
            t_ack = 1'b1;
            settle();
            chk($sformatf("t4_gnt_b%0d", b), gnt, 4'b0001);
            chk($sformatf("t4_ack_b%0d", b), i_ack, 4'b0001);
            chk($sformatf("t4_adr_b%0d", b), t_adr, 32'h200 + 32'(b * 4));
            tick();
        end
        t_ack = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        settle();
        chk("t4_drop_t_cyc", t_cyc, 0);
        tick();
        chk("t4_idle", gnt, 0);
        tick();
        chk("t4_gnt1", gnt, 4'b0010);
        chk("t4_t_adr1", t_adr, 32'h300);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();

        // 5: watchdog expiry, late ack discarded, next initiator granted
        drive(3, 1, 1, 0, 32'h0000_0400, 32'h0);
        tick();
        chk("t5_gnt3", gnt, 4'b1000);
        chk("t5_stb_rise", t_stb, 1);
        for (int j = 1; j < TO; j++) begin
            tick();
            chk($sformatf("t5_wait_err_%0d", j), i_err, 0);
            chk($sformatf("t5_wait_cyc_%0d", j), t_cyc, 1);
        end
        tick();
        chk("t5_err", i_err, 4'b1000);
        chk("t5_err_state", dbg_state, 1);
        tick();
        chk("t5_abort_t_cyc", t_cyc, 0);
        chk("t5_err_once", i_err, 0);
        chk("t5_abort_state", dbg_state, 2);
        drive(0, 1, 1, 0, 32'h0000_0500, 32'h0);
        t_ack = 1'b1;
        settle();
        chk("t5_late_ack", i_ack, 0);
        chk("t5_abort_gnt", gnt, 4'b1000);
        tick();
        t_ack = 1'b0;
        drive(3, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("t5_idle", gnt, 0);
        tick();
        chk("t5_next_gnt", gnt, 4'b0001);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();

        // Ack arriving in the expiry cycle wins over the watchdog
        drive(1, 1, 1, 0, 32'h0000_0600, 32'h0);
        tick();
        chk("t7_gnt1", gnt, 4'b0010);
        repeat (TO) tick();
        t_ack = 1'b1;
        settle();
        chk("t7_ack", i_ack, 4'b0010);
        chk("t7_no_err", i_err, 0);
        tick();
        t_ack = 1'b0;
        settle();
        chk("t7_no_abort", dbg_state, 1);
        chk("t7_t_cyc", t_cyc, 1);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();

        // 6: error pass-through on a read by initiator 2
        drive(2, 1, 1, 0, 32'h0000_0700, 32'h0);
        tick();
        chk("t6_gnt2", gnt, 4'b0100);
        chk("t6_t_we", t_we, 0);
        t_dat_r = 32'hCAFE_F00D;
        t_err   = 1'b1;
        settle();
        chk("t6_err", i_err, 4'b0100);
        chk("t6_no_ack", i_ack, 0);
        chk("t6_dat_r", i_dat_r, 32'hCAFE_F00D);
        tick();
        t_err = 1'b0;
        settle();
        chk("t6_err_once", i_err, 0);
        chk("t6_no_abort", dbg_state, 1);
        chk("t6_t_cyc", t_cyc, 1);
        t_ack = 1'b1;
        t_err = 1'b1;
        settle();
        chk("t6_both_ack", i_ack, 4'b0100);
        chk("t6_both_err", i_err, 4'b0100);
        tick();
        t_ack = 1'b0;
        t_err = 1'b0;
        drive(2, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("t6_idle", gnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
